// File: rtl/cam_lookup_ctrl_pkg.sv
// Shared types and constants for the CAM lookup/insert request sequencer.
package cam_lookup_ctrl_pkg;

  localparam int DEF_CAM_DEPTH = 8;
  localparam int DEF_CAM_WIDTH = 48;
  localparam int DEF_CAM_PTR   = 3;
  localparam int DEF_CNT_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEARCH = 3'd1,
    ST_CHECK  = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  // Response bundle is {hit, inserted, evicted, addr}; flags sit above the address.
  localparam int RSP_FLAG_W   = 3;
  localparam int RSP_BUNDLE_W = RSP_FLAG_W + DEF_CAM_PTR;

endpackage

// File: rtl/cam_lookup_ctrl_first_empty.sv
// Priority encoder: reports whether any CAM entry is free and the lowest free index.
module cam_first_empty
  import cam_lookup_ctrl_pkg::*;
#(
  parameter int CAM_DEPTH = DEF_CAM_DEPTH,
  parameter int CAM_PTR   = DEF_CAM_PTR
) (
  input  logic [0:CAM_DEPTH-1] i_valid_status,
  output logic                 o_found,
  output logic [CAM_PTR-1:0]   o_idx
);

  // Scan from the top down so the lowest empty index is the last one written.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
      if (!i_valid_status[i]) begin
        o_found = 1'b1;
        o_idx   = CAM_PTR'(i);
      end
    end
  end

endmodule

// File: rtl/cam_lookup_ctrl.sv
// Sequences one lookup/insert at a time against the CAM: search, check, optional write, respond.
module cam_lookup_ctrl
  import cam_lookup_ctrl_pkg::*;
#(
  parameter int CAM_DEPTH = DEF_CAM_DEPTH,
  parameter int CAM_WIDTH = DEF_CAM_WIDTH,
  parameter int CAM_PTR   = DEF_CAM_PTR,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  input  logic [CAM_WIDTH-1:0] i_req_key,
  input  logic                 i_req_insert,
  output logic                 o_req_ready,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic                 o_rsp_hit,
  output logic [CAM_PTR-1:0]   o_rsp_addr,
  output logic                 o_rsp_inserted,
  output logic                 o_rsp_evicted,
  output logic                 o_cam_search,
  output logic [CAM_WIDTH-1:0] o_cam_contents,
  output logic                 o_cam_write,
  output logic [CAM_PTR-1:0]   o_cam_wr_addr,
  input  logic                 i_cam_match,
  input  logic [CAM_PTR-1:0]   i_cam_match_addr,
  input  logic [0:CAM_DEPTH-1] i_cam_valid_status,
  output logic [CNT_WIDTH-1:0] o_hit_cnt,
  output logic [CNT_WIDTH-1:0] o_miss_cnt,
  output logic [CNT_WIDTH-1:0] o_evict_cnt
);

  localparam int RSP_W = RSP_FLAG_W + CAM_PTR;

  state_t               state_q, state_d;
  logic [CAM_WIDTH-1:0] key_q, key_d;
  logic                 insert_q, insert_d;
  logic [CAM_PTR-1:0]   target_q, target_d;
  logic [CAM_PTR-1:0]   ptr_q, ptr_d;
  logic [RSP_W-1:0]     rsp_q, rsp_d;
  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
  logic [CNT_WIDTH-1:0] evict_cnt_q, evict_cnt_d;

  logic                 empty_found;
  logic [CAM_PTR-1:0]   empty_idx;
  logic                 inc_hit, inc_miss, inc_evict;

  cam_first_empty #(
    .CAM_DEPTH (CAM_DEPTH),
    .CAM_PTR   (CAM_PTR)
  ) u_first_empty (
    .i_valid_status (i_cam_valid_status),
    .o_found        (empty_found),
    .o_idx          (empty_idx)
  );

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    insert_d  = insert_q;
    target_d  = target_q;
    ptr_d     = ptr_q;
    rsp_d     = rsp_q;
    inc_hit   = 1'b0;
    inc_miss  = 1'b0;
    inc_evict = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          key_d    = i_req_key;
          insert_d = i_req_insert;
          rsp_d    = '0;
          state_d  = ST_SEARCH;
        end
      end
      ST_SEARCH: state_d = ST_CHECK;
      ST_CHECK: begin
        if (i_cam_match) begin
          inc_hit = 1'b1;
          rsp_d   = {1'b1, 1'b0, 1'b0, i_cam_match_addr};
          state_d = ST_RESP;
        end else begin
          inc_miss = 1'b1;
          rsp_d    = '0;
          if (!insert_q) begin
            state_d = ST_RESP;
          end else begin
            // Only a full CAM consumes the round-robin victim pointer.
            if (empty_found) begin
              target_d = empty_idx;
            end else begin
              target_d         = ptr_q;
              rsp_d[RSP_W-3]   = 1'b1;
              inc_evict        = 1'b1;
              ptr_d            = (ptr_q == CAM_PTR'(CAM_DEPTH - 1)) ? '0 : ptr_q + CAM_PTR'(1);
            end
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        rsp_d[RSP_W-2]     = 1'b1;
        rsp_d[CAM_PTR-1:0] = target_q;
        state_d            = ST_RESP;
      end
      ST_RESP: begin
        if (i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    hit_cnt_d   = (inc_hit   && !(&hit_cnt_q))   ? hit_cnt_q   + CNT_WIDTH'(1) : hit_cnt_q;
    miss_cnt_d  = (inc_miss  && !(&miss_cnt_q))  ? miss_cnt_q  + CNT_WIDTH'(1) : miss_cnt_q;
    evict_cnt_d = (inc_evict && !(&evict_cnt_q)) ? evict_cnt_q + CNT_WIDTH'(1) : evict_cnt_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      key_q       <= '0;
      insert_q    <= 1'b0;
      target_q    <= '0;
      ptr_q       <= '0;
      rsp_q       <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      evict_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      insert_q    <= insert_d;
      target_q    <= target_d;
      ptr_q       <= ptr_d;
      rsp_q       <= rsp_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      evict_cnt_q <= evict_cnt_d;
    end
  end

  assign o_req_ready    = (state_q == ST_IDLE);
  assign o_rsp_valid    = (state_q == ST_RESP);
  assign o_cam_search   = (state_q == ST_SEARCH);
  assign o_cam_write    = (state_q == ST_WRITE);
  assign o_cam_wr_addr  = o_cam_write ? target_q : '0;
  assign o_cam_contents = (o_cam_search || o_cam_write) ? key_q : '0;

  assign o_rsp_hit      = rsp_q[RSP_W-1];
  assign o_rsp_inserted = rsp_q[RSP_W-2];
  assign o_rsp_evicted  = rsp_q[RSP_W-3];
  assign o_rsp_addr     = rsp_q[CAM_PTR-1:0];

  assign o_hit_cnt      = hit_cnt_q;
  assign o_miss_cnt     = miss_cnt_q;
  assign o_evict_cnt    = evict_cnt_q;

endmodule
